// File: rtl/veggie_pkg.sv
// Shared types and constants for the veggie flight physics.
// Holds the state enum, the frame line and the datapath widths.
package veggie_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FLYING = 2'd1,
    ST_SPLIT  = 2'd2,
    ST_GONE   = 2'd3
  } veggie_state_e;

  localparam int FRAME_LINE = 768;

  localparam int X_W    = 11;
  localparam int Y_W    = 10;
  localparam int V_W    = 8;
  localparam int RUN_W  = 11;
  localparam int RISE_W = 10;
  localparam int SEP_W  = 8;
  localparam int CALC_W = 12;

  function automatic logic [SEP_W-1:0] sep_grow(
    input logic [SEP_W-1:0] sep,
    input int unsigned      step
  );
    logic [SEP_W:0] sum;
    sum = {1'b0, sep} + (SEP_W+1)'(step);
    return sum[SEP_W] ? {SEP_W{1'b1}} : sum[SEP_W-1:0];
  endfunction

endpackage

// File: rtl/veggie_physics_frame_strobe.sv
// One-cycle frame tick at the start of the frame line.
// A latch-out flag keeps it to one pulse per frame.
module frame_strobe
  import veggie_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [10:0] i_hcount,
  input  logic [9:0]  i_vcount,
  output logic        o_tick
);

  logic w_line;
  logic w_hit;
  logic r_fired;

  assign w_line = (i_vcount == 10'(FRAME_LINE));
  assign w_hit  = w_line && (i_hcount == '0);
  assign o_tick = w_hit && !r_fired;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_fired <= 1'b0;
    end else if (w_hit) begin
      r_fired <= 1'b1;
    end else if (!w_line) begin
      r_fired <= 1'b0;
    end
  end

endmodule

// File: rtl/veggie_physics.sv
// Per-frame ballistic motion, blade split and exit detection
// for a single launched veggie.
module veggie_physics
  import veggie_pkg::*;
#(
  parameter int GRAVITY  = 1,
  parameter int LAUNCH_Y = 767,
  parameter int GONE_Y   = 900,
  parameter int SCREEN_W = 1024,
  parameter int SEP_STEP = 2
) (
  input  logic               pixel_clk_in,
  input  logic               rst_in,
  input  logic [10:0]        hcount_in,
  input  logic [9:0]         vcount_in,
  input  logic               launch_in,
  input  logic [10:0]        launch_x_in,
  input  logic signed [7:0]  launch_vx_in,
  input  logic signed [7:0]  launch_vy_in,
  input  logic               slice_in,
  input  logic signed [10:0] run_in,
  input  logic signed [9:0]  rise_in,
  output logic [10:0]        x_out,
  output logic [9:0]         y_out,
  output logic               split_out,
  output logic signed [10:0] run_out,
  output logic signed [9:0]  rise_out,
  output logic [7:0]         sep_out,
  output logic               veggie_gone_out,
  output logic               active_out
);

  veggie_state_e r_state;

  logic [X_W-1:0]           r_x;
  logic [Y_W-1:0]           r_y;
  logic signed [V_W-1:0]    r_vx;
  logic signed [V_W-1:0]    r_vy;
  logic [SEP_W-1:0]         r_sep;
  logic signed [RUN_W-1:0]  r_run;
  logic signed [RISE_W-1:0] r_rise;
  logic                     r_split;
  logic                     r_gone;

  logic                     w_tick;
  logic signed [CALC_W-1:0] w_x_nx;
  logic signed [CALC_W-1:0] w_y_nx;
  logic signed [CALC_W-1:0] w_vy_inc;
  logic signed [V_W-1:0]    w_vy_sat;
  logic                     w_y_neg;
  logic [Y_W-1:0]           w_y_upd;
  logic signed [V_W-1:0]    w_vy_upd;
  logic                     w_exit;
  logic                     w_flat;
  logic signed [RUN_W-1:0]  w_run_sel;
  logic signed [RISE_W-1:0] w_rise_sel;

  frame_strobe u_strobe (
    .i_clk    (pixel_clk_in),
    .i_rst    (rst_in),
    .i_hcount (hcount_in),
    .i_vcount (vcount_in),
    .o_tick   (w_tick)
  );

  assign w_x_nx   = $signed({1'b0, r_x}) + CALC_W'(r_vx);
  assign w_y_nx   = $signed({2'b00, r_y}) + CALC_W'(r_vy);
  assign w_vy_inc = CALC_W'(r_vy) + CALC_W'(GRAVITY);
  assign w_vy_sat = (w_vy_inc > CALC_W'(127)) ?
                    8'sd127 : w_vy_inc[V_W-1:0];

  // Hitting the top edge stops the climb dead.
  assign w_y_neg  = (w_y_nx < 0);
  assign w_y_upd  = w_y_neg ? '0 : w_y_nx[Y_W-1:0];
  assign w_vy_upd = w_y_neg ? '0 : w_vy_sat;

  assign w_exit = (w_x_nx < 0)
               || (w_x_nx > CALC_W'(SCREEN_W - 1))
               || ((w_y_nx >= CALC_W'(GONE_Y)) && (r_vy >= 0));

  // A null blade direction falls back to a horizontal cut.
  assign w_flat     = (run_in == '0) && (rise_in == '0);
  assign w_run_sel  = w_flat ? 11'sd1 : run_in;
  assign w_rise_sel = w_flat ? 10'sd0 : rise_in;

  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state <= ST_IDLE;
      r_x     <= '0;
      r_y     <= '0;
      r_vx    <= '0;
      r_vy    <= '0;
      r_sep   <= '0;
      r_run   <= '0;
      r_rise  <= '0;
      r_split <= 1'b0;
      r_gone  <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE, ST_GONE: begin
          if (launch_in) begin
            r_state <= ST_FLYING;
            r_x     <= launch_x_in;
            r_y     <= Y_W'(LAUNCH_Y);
            r_vx    <= launch_vx_in;
            r_vy    <= launch_vy_in;
            r_sep   <= '0;
            r_split <= 1'b0;
            r_gone  <= 1'b0;
          end
        end
        ST_FLYING, ST_SPLIT: begin
          if (w_tick && w_exit) begin
            r_state <= ST_GONE;
            r_gone  <= 1'b1;
          end else begin
            if (w_tick) begin
              r_x  <= w_x_nx[X_W-1:0];
              r_y  <= w_y_upd;
              r_vy <= w_vy_upd;
              if (r_state == ST_SPLIT) begin
                r_sep <= sep_grow(r_sep, SEP_STEP);
              end
            end
            if (r_state == ST_FLYING && slice_in) begin
              r_state <= ST_SPLIT;
              r_run   <= w_run_sel;
              r_rise  <= w_rise_sel;
              r_split <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign x_out           = r_x;
  assign y_out           = r_y;
  assign split_out       = r_split;
  assign run_out         = r_run;
  assign rise_out        = r_rise;
  assign sep_out         = r_sep;
  assign veggie_gone_out = r_gone;
  assign active_out      = (r_state == ST_FLYING)
                        || (r_state == ST_SPLIT);

endmodule

// File: tb/tb_veggie_physics.sv
// Scoreboard bench for veggie_physics: flight, split, exit,
// ignored requests and asynchronous reset.
module tb_veggie_physics;

  logic               clk = 1'b0;
  logic               rst_in;
  logic [10:0]        hcount_in;
  logic [9:0]         vcount_in;
  logic               launch_in;
  logic [10:0]        launch_x_in;
  logic signed [7:0]  launch_vx_in;
  logic signed [7:0]  launch_vy_in;
  logic               slice_in;
  logic signed [10:0] run_in;
  logic signed [9:0]  rise_in;
  logic [10:0]        x_out;
  logic [9:0]         y_out;
  logic               split_out;
  logic signed [10:0] run_out;
  logic signed [9:0]  rise_out;
  logic [7:0]         sep_out;
  logic               veggie_gone_out;
  logic               active_out;

  always #5 clk = ~clk;

  veggie_physics dut (
    .pixel_clk_in    (clk),
    .rst_in          (rst_in),
    .hcount_in       (hcount_in),
    .vcount_in       (vcount_in),
    .launch_in       (launch_in),
    .launch_x_in     (launch_x_in),
    .launch_vx_in    (launch_vx_in),
    .launch_vy_in    (launch_vy_in),
    .slice_in        (slice_in),
    .run_in          (run_in),
    .rise_in         (rise_in),
    .x_out           (x_out),
    .y_out           (y_out),
    .split_out       (split_out),
    .run_out         (run_out),
    .rise_out        (rise_out),
    .sep_out         (sep_out),
    .veggie_gone_out (veggie_gone_out),
    .active_out      (active_out)
  );

  typedef struct {
    string       tag;
    logic [10:0] x;
    logic [9:0]  y;
    logic        split;
    logic [10:0] run;
    logic [9:0]  rise;
    logic [7:0]  sep;
    logic        gone;
    logic        act;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic expect_out(input string tag,
                            input int x, input int y,
                            input bit split,
                            input int run, input int rise,
                            input int sep,
                            input bit gone, input bit act);
    exp_t e;
    e.tag   = tag;
    e.x     = 11'(x);
    e.y     = 10'(y);
    e.split = split;
    e.run   = 11'(run);
    e.rise  = 10'(rise);
    e.sep   = 8'(sep);
    e.gone  = gone;
    e.act   = act;
    sb.push_back(e);
  endtask

  task automatic compare_out();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL sb_empty got=0 exp=1");
    end else begin
      e = sb.pop_front();
      chk({e.tag, ".x"}, {21'b0, x_out}, {21'b0, e.x});
      chk({e.tag, ".y"}, {22'b0, y_out}, {22'b0, e.y});
      chk({e.tag, ".split"}, {31'b0, split_out},
          {31'b0, e.split});
      chk({e.tag, ".run"}, {21'b0, run_out}, {21'b0, e.run});
      chk({e.tag, ".rise"}, {22'b0, rise_out},
          {22'b0, e.rise});
      chk({e.tag, ".sep"}, {24'b0, sep_out}, {24'b0, e.sep});
      chk({e.tag, ".gone"}, {31'b0, veggie_gone_out},
          {31'b0, e.gone});
      chk({e.tag, ".act"}, {31'b0, active_out},
          {31'b0, e.act});
    end
  endtask

  // One stimulus edge, then an idle edge so the strobe re-arms.
  task automatic step(input bit lau, input bit slc,
                      input bit tk);
    launch_in = lau;
    slice_in  = slc;
    if (tk) begin
      hcount_in = 11'd0;
      vcount_in = 10'd768;
    end
    @(posedge clk); #1;
    launch_in = 1'b0;
    slice_in  = 1'b0;
    hcount_in = 11'd5;
    vcount_in = 10'd100;
    compare_out();
    @(posedge clk); #1;
  endtask

  task automatic pulse_reset();
    rst_in = 1'b1;
    #2;
    compare_out();
    @(posedge clk); #1;
    rst_in = 1'b0;
    @(posedge clk); #1;
  endtask

  int fall_y[9] = '{777, 788, 800, 813, 827, 842, 858, 875, 893};

  initial begin
    rst_in       = 1'b1;
    hcount_in    = 11'd5;
    vcount_in    = 10'd100;
    launch_in    = 1'b0;
    launch_x_in  = '0;
    launch_vx_in = '0;
    launch_vy_in = '0;
    slice_in     = 1'b0;
    run_in       = '0;
    rise_in      = '0;
    @(posedge clk); #1;
    expect_out("reset", 0, 0, 0, 0, 0, 0, 0, 0);
    compare_out();
    rst_in = 1'b0;
    @(posedge clk); #1;

    launch_x_in  = 11'd512;
    launch_vx_in = 8'sd3;
    launch_vy_in = -8'sd20;
    expect_out("launch", 512, 767, 0, 0, 0, 0, 0, 1);
    step(1, 0, 0);

    // Raster parked on the tick point for two edges.
    hcount_in = 11'd0;
    vcount_in = 10'd768;
    expect_out("tick1", 515, 747, 0, 0, 0, 0, 0, 1);
    @(posedge clk); #1;
    compare_out();
    expect_out("tick_once", 515, 747, 0, 0, 0, 0, 0, 1);
    @(posedge clk); #1;
    compare_out();
    hcount_in = 11'd5;
    vcount_in = 10'd100;
    @(posedge clk); #1;

    expect_out("tick2", 518, 728, 0, 0, 0, 0, 0, 1);
    step(0, 0, 1);
    expect_out("tick3", 521, 710, 0, 0, 0, 0, 0, 1);
    step(0, 0, 1);

    launch_x_in = 11'd100;
    expect_out("launch_fly", 521, 710, 0, 0, 0, 0, 0, 1);
    step(1, 0, 0);

    run_in  = 11'sd5;
    rise_in = -10'sd2;
    expect_out("slice", 521, 710, 1, 5, -2, 0, 0, 1);
    step(0, 1, 0);
    expect_out("split_t1", 524, 693, 1, 5, -2, 2, 0, 1);
    step(0, 0, 1);
    run_in  = 11'sd7;
    rise_in = 10'sd7;
    expect_out("split_t2", 527, 677, 1, 5, -2, 4, 0, 1);
    step(0, 1, 1);
    expect_out("split_t3", 530, 662, 1, 5, -2, 6, 0, 1);
    step(0, 0, 1);

    expect_out("rst_split", 0, 0, 0, 0, 0, 0, 0, 0);
    pulse_reset();

    run_in  = 11'sd3;
    rise_in = 10'sd3;
    expect_out("slice_idle", 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 1);

    launch_x_in  = 11'd100;
    launch_vx_in = 8'sd0;
    launch_vy_in = 8'sd10;
    expect_out("launch_fall", 100, 767, 0, 0, 0, 0, 0, 1);
    step(1, 0, 0);
    for (int i = 0; i < 9; i++) begin
      expect_out($sformatf("fall%0d", i), 100, fall_y[i],
                 0, 0, 0, 0, 0, 1);
      step(0, 0, 1);
    end
    expect_out("fall_gone", 100, 893, 0, 0, 0, 0, 1, 0);
    step(0, 0, 1);
    expect_out("gone_hold", 100, 893, 0, 0, 0, 0, 1, 0);
    step(0, 1, 1);

    launch_x_in  = 11'd1022;
    launch_vx_in = 8'sd5;
    launch_vy_in = 8'sd0;
    expect_out("relaunch", 1022, 767, 0, 0, 0, 0, 0, 1);
    step(1, 0, 0);
    expect_out("right_exit", 1022, 767, 0, 0, 0, 0, 1, 0);
    step(0, 0, 1);

    launch_x_in  = 11'd200;
    launch_vx_in = 8'sd1;
    run_in       = '0;
    rise_in      = '0;
    expect_out("launch_flat", 200, 767, 0, 0, 0, 0, 0, 1);
    step(1, 0, 0);
    expect_out("flat_slice", 201, 767, 1, 1, 0, 0, 0, 1);
    step(0, 1, 1);
    expect_out("flat_t1", 202, 768, 1, 1, 0, 2, 0, 1);
    step(0, 0, 1);

    expect_out("rst2", 0, 0, 0, 0, 0, 0, 0, 0);
    pulse_reset();
    launch_x_in  = 11'd0;
    launch_vx_in = -8'sd1;
    expect_out("launch_left", 0, 767, 0, 0, 0, 0, 0, 1);
    step(1, 0, 0);
    run_in  = 11'sd4;
    rise_in = 10'sd4;
    expect_out("exit_slice", 0, 767, 0, 0, 0, 0, 1, 0);
    step(0, 1, 1);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/veggie_physics.md
VEGGIE_PHYSICS -- requirements
Module: veggie_physics

Interface
REQ-001 SHALL have parameter GRAVITY, default 1, meaning vertical velocity increment in px/frame per frame.
REQ-002 SHALL have parameter LAUNCH_Y, default 767, meaning y position loaded on launch.
REQ-003 SHALL have parameter GONE_Y, default 900, meaning the y at or beyond which a falling veggie is gone.
REQ-004 SHALL have parameter SCREEN_W, default 1024, meaning the horizontal playfield width in px.
REQ-005 SHALL have parameter SEP_STEP, default 2, meaning half-separation growth in px/frame after a split.
REQ-006 SHALL have port pixel_clk_in, input, 1 bit: the single clock.
REQ-007 SHALL have port rst_in, input, 1 bit: reset, asynchronous and active-high.
REQ-008 SHALL have ports hcount_in [10:0] and vcount_in [9:0], inputs: raster position.
REQ-009 SHALL have port launch_in, input, 1 bit: launch request pulse.
REQ-010 SHALL have ports launch_x_in [10:0], launch_vx_in signed [7:0] and launch_vy_in signed [7:0], inputs: launch parameters.
REQ-011 SHALL have port slice_in, input, 1 bit: blade-hit pulse.
REQ-012 SHALL have ports run_in signed [10:0] and rise_in signed [9:0], inputs: blade direction.
REQ-013 SHALL have ports x_out [10:0] and y_out [9:0], outputs: veggie centre.
REQ-014 SHALL have port split_out, output, 1 bit: veggie is split.
REQ-015 SHALL have ports run_out signed [10:0] and rise_out signed [9:0], outputs: latched cut direction.
REQ-016 SHALL have port sep_out [7:0], output: half separation in px.
REQ-017 SHALL have port veggie_gone_out, output, 1 bit: veggie has left the playfield.
REQ-018 SHALL have port active_out, output, 1 bit: veggie is FLYING or SPLIT.

Function
REQ-019 SHALL generate frame_tick as a one-cycle pulse when hcount_in==0 and vcount_in==768, at most once per frame.
REQ-020 SHALL implement the states IDLE, FLYING, SPLIT and GONE.
REQ-021 SHALL, on launch_in in IDLE or GONE, enter FLYING on the next edge with x=launch_x_in, y=LAUNCH_Y, vx=launch_vx_in, vy=launch_vy_in, sep=0, split_out=0 and veggie_gone_out=0.
REQ-022 SHALL ignore launch_in in FLYING and SPLIT.
REQ-023 SHALL, on frame_tick in FLYING or SPLIT, compute in 12-bit signed arithmetic x+=vx, y+=vy and vy=min(vy+GRAVITY, 127), with all outputs registered and valid one cycle after frame_tick.
REQ-024 SHALL, when y_next<0, clamp y to 0 and set vy to 0.
REQ-025 SHALL, when x_next<0, or x_next>SCREEN_W-1, or (y_next>=GONE_Y and vy>=0), enter GONE with veggie_gone_out=1 and hold x and y.
REQ-026 SHALL, on slice_in in FLYING, enter SPLIT, latch run_out and rise_out, and set split_out=1.
REQ-027 SHALL, when run_in==0 and rise_in==0, latch run=1 and rise=0.
REQ-028 SHALL ignore slice_in outside FLYING.
REQ-029 SHALL, in SPLIT, increase sep_out by SEP_STEP on each frame_tick, saturating at 255.
REQ-030 SHALL, on slice_in coincident with frame_tick, apply both the motion update and the split.
REQ-031 SHALL, on a gone condition coincident with slice_in, enter GONE and ignore the slice.
REQ-032 SHALL hold veggie_gone_out high in GONE until the next accepted launch.
REQ-033 SHALL remain in GONE until launch_in.

Reset
REQ-034 SHALL, on rst_in asserted at any time including mid-flight, immediately enter IDLE and zero all outputs, x, y, vx, vy and sep.
REQ-035 SHALL resume operation on the first edge after rst_in deasserts, with launch_in required to restart.

Structure
REQ-036 SHALL take the state enum, the frame-line constant 768 and the velocity and position widths from the shared package veggie_pkg.
REQ-037 SHALL implement frame_tick generation as the sub-module frame_strobe.
REQ-038 SHALL keep output port widths matching the downstream split-sprite inputs exactly.

Verification
REQ-039 SHALL cover: launch x=512, vx=3, vy=-20, then 3 frame_ticks -> x=521, y=710, vy=-17.
REQ-040 SHALL cover: slice_in with run=5, rise=-2 mid-flight -> split_out=1, run_out=5, rise_out=-2, sep_out=2,4,6 on the following ticks.
REQ-041 SHALL cover: a falling veggie crossing y=900 -> veggie_gone_out=1 and state GONE; then launch_in -> gone cleared, state FLYING.
REQ-042 SHALL cover: x=1022, vx=5, then frame_tick -> GONE with x held at 1022.
REQ-043 SHALL cover: slice_in in IDLE and launch_in in FLYING -> no state change; run=0, rise=0 slice -> run_out=1, rise_out=0.
REQ-044 SHALL cover: rst_in pulsed mid-SPLIT -> all outputs 0 in the same cycle, state IDLE.
